power_switch_sequencer: RTL and testbench
=========================================

POWER_SWITCH_SEQUENCER -- requirements
Module: power_switch_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: switch stages per domain, legal range 1..32.
REQ-002 SHALL have parameter DLY_W, default 8: width of the inter-stage delay value.
REQ-003 SHALL have parameter TMO_W, default 10: width of the ack-timeout counter.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port pwr_req  in  1  level request: 1 = domain on, 0 = domain off.
REQ-007 SHALL have port stage_dly  in  DLY_W  minimum cycles between successive stage toggles.
REQ-008 SHALL have port stage_ack  in  NUM_STAGES  per-stage switch acknowledge, synchronous to clk: 1 = conducting.
REQ-009 SHALL have port err_clr  in  1  single-cycle clear of the error state.
REQ-010 SHALL have port sleep_n_stages  out  NUM_STAGES  registered active-low sleep controls, one per stage.
REQ-011 SHALL have port pwr_ack  out  1  1 = all stages on and acknowledged.
REQ-012 SHALL have port busy  out  1  1 = ramp up or ramp down in progress.
REQ-013 SHALL have port err  out  1  1 = ack timeout occurred; switches forced off.

Function
REQ-014 SHALL implement the states OFF, UP, ON, DOWN and ERR, with one stage index idx in 0..NUM_STAGES-1.
REQ-015 SHALL latch stage_dly into D on every entry to UP or DOWN, treating 0 as 1; mid-sequence changes to stage_dly SHALL be ignored.
REQ-016 In OFF, with pwr_req=1 sampled at cycle N, SHALL enter UP and assert sleep_n_stages[0] at N+1 with idx=0.
REQ-017 In UP, SHALL assert stage idx+1 in the cycle after the condition (dly_cnt >= D-1 AND stage_ack[idx]=1) holds; dly_cnt=0 in the first cycle stage idx is on.
REQ-018 In UP, once the condition of REQ-017 holds for the last stage, SHALL enter ON and assert pwr_ack the following cycle.
REQ-019 With acks already high, power-up latency SHALL be exactly 1+NUM_STAGES*D cycles from pwr_req sample to pwr_ack=1.
REQ-020 In ON, with pwr_req=0 sampled, SHALL deassert pwr_ack next cycle, enter DOWN, and clear the highest stage first.
REQ-021 In DOWN, SHALL clear stage idx-1 when dly_cnt >= D-1 AND stage_ack[idx]=0; after stage 0 satisfies this, SHALL enter OFF.
REQ-022 SHALL keep stage enables thermometer-coded at all times: stage k on implies stages 0..k-1 on.
REQ-023 If pwr_req falls during UP, SHALL enter DOWN starting from the highest enabled stage, without enabling any further stage.
REQ-024 If pwr_req rises during DOWN, SHALL enter UP, enabling the next stage above the highest enabled one; if no stage is enabled, SHALL enable stage 0.
REQ-025 SHALL count tmo_cnt while the delay has elapsed but the ack condition is unmet; on reaching 2^TMO_W-1, SHALL enter ERR next cycle.
REQ-026 In ERR, SHALL drive all sleep_n_stages=0 simultaneously, err=1, pwr_ack=0 and busy=0.
REQ-027 SHALL leave ERR for OFF only when err_clr=1 AND pwr_req=0 in the same cycle; err_clr in any other state SHALL have no effect.
REQ-028 busy SHALL equal 1 exactly in UP and DOWN.
REQ-029 pwr_ack SHALL equal 1 only in ON.
REQ-030 When NUM_STAGES=1, SHALL behave identically, with one stage and no index advance.

Reset
REQ-031 On rst_n=0, SHALL immediately (asynchronously) enter OFF and drive sleep_n_stages=0, pwr_ack=0, busy=0 and err=0, with idx, dly_cnt and tmo_cnt all 0.
REQ-032 SHALL treat reset during UP, ON or DOWN as an abrupt cut to OFF with no sequencing, and begin a fresh UP after release only if pwr_req=1.

Verification
REQ-033 NUM_STAGES=4, stage_dly=3, stage_ack tracking sleep_n after 1 cycle, pwr_req 0->1 -> stages 0001,0011,0111,1111 spaced 3 cycles, pwr_ack=1 at cycle 13.
REQ-034 In ON, pwr_req->0, stage_dly=2 -> 0111,0011,0001,0000 spaced >=2 cycles, busy=1 throughout, OFF after stage 0 acks low.
REQ-035 pwr_req pulled low while sleep_n_stages=0011 in UP -> no 0111 ever appears; next is 0001, then 0000.
REQ-036 TMO_W=4, stage_ack[1] stuck 0 -> ERR after 15 cycles of waiting; sleep_n_stages=0000 and err=1; err_clr with pwr_req=1 ignored; err_clr with pwr_req=0 -> OFF, err=0.
REQ-037 stage_dly=0 -> stages spaced 1 cycle; rst_n asserted at 0111 -> outputs 0000 with no clock edge needed.

Source files
------------

// File: rtl/power_switch_sequencer.sv
// Power-gating switch sequencer: ramps a domain's sleep switches on and off one stage at a time,
// paced by a latched inter-stage delay and per-stage acknowledges, with an ack-timeout error state.
module power_switch_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int DLY_W      = 8,
    parameter int TMO_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwr_req,
    input  logic [DLY_W-1:0]      stage_dly,
    input  logic [NUM_STAGES-1:0] stage_ack,
    input  logic                  err_clr,
    output logic [NUM_STAGES-1:0] sleep_n_stages,
    output logic                  pwr_ack,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_STAGES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    typedef enum logic [2:0] {S_OFF, S_UP, S_ON, S_DOWN, S_ERR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DLY_W-1:0]  dly_cnt;
    logic [DLY_W-1:0]  d_lat;
    logic [TMO_W-1:0]  tmo_cnt;

    logic elapsed;
    logic up_ok;
    logic down_ok;

    // A programmed delay of zero still spaces stages by one cycle.
    function automatic logic [DLY_W-1:0] clamp_dly(input logic [DLY_W-1:0] v);
        return (v == '0) ? DLY_W'(1) : v;
    endfunction

    // idx always names the stage most recently toggled; its ack gates the next toggle.
    assign elapsed = (dly_cnt >= (d_lat - DLY_W'(1)));
    assign up_ok   = elapsed && stage_ack[idx];
    assign down_ok = elapsed && !stage_ack[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_OFF;
            idx            <= '0;
            dly_cnt        <= '0;
            d_lat          <= '0;
            tmo_cnt        <= '0;
            sleep_n_stages <= '0;
            pwr_ack        <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    if (pwr_req) begin
                        state             <= S_UP;
                        busy              <= 1'b1;
                        idx               <= '0;
                        sleep_n_stages    <= NUM_STAGES'(1);
                        d_lat             <= clamp_dly(stage_dly);
                        dly_cnt           <= '0;
                        tmo_cnt           <= '0;
                    end
                end

                S_UP: begin
                    if (tmo_cnt == TMO_MAX) begin
                        state          <= S_ERR;
                        sleep_n_stages <= '0;
                        busy           <= 1'b0;
                        err            <= 1'b1;
                        idx            <= '0;
                        dly_cnt        <= '0;
                        tmo_cnt        <= '0;
                    end else if (!pwr_req) begin
                        // Reverse from the highest enabled stage without enabling more.
                        state               <= S_DOWN;
                        sleep_n_stages[idx] <= 1'b0;
                        d_lat               <= clamp_dly(stage_dly);
                        dly_cnt             <= '0;
                        tmo_cnt             <= '0;
                    end else if (up_ok) begin
                        dly_cnt <= '0;
                        tmo_cnt <= '0;
                        if (idx == LAST) begin
                            state   <= S_ON;
                            busy    <= 1'b0;
                            pwr_ack <= 1'b1;
                        end else begin
                            idx                        <= idx + 1'b1;
                            sleep_n_stages[idx + 1'b1] <= 1'b1;
                        end
                    end else if (!elapsed) begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_ON: begin
                    if (!pwr_req) begin
                        state                <= S_DOWN;
                        pwr_ack              <= 1'b0;
                        busy                 <= 1'b1;
                        idx                  <= LAST;
                        sleep_n_stages[LAST] <= 1'b0;
                        d_lat                <= clamp_dly(stage_dly);
                        dly_cnt              <= '0;
                        tmo_cnt              <= '0;
                    end
                end

                S_DOWN: begin
                    if (tmo_cnt == TMO_MAX) begin
                        state          <= S_ERR;
                        sleep_n_stages <= '0;
                        busy           <= 1'b0;
                        err            <= 1'b1;
                        idx            <= '0;
                        dly_cnt        <= '0;
                        tmo_cnt        <= '0;
                    end else if (pwr_req) begin
                        // Stage idx is the one just cleared, i.e. next above the highest enabled.
                        state               <= S_UP;
                        sleep_n_stages[idx] <= 1'b1;
                        d_lat               <= clamp_dly(stage_dly);
                        dly_cnt             <= '0;
                        tmo_cnt             <= '0;
                    end else if (down_ok) begin
                        dly_cnt <= '0;
                        tmo_cnt <= '0;
                        if (idx == '0) begin
                            state <= S_OFF;
                            busy  <= 1'b0;
                        end else begin
                            idx                        <= idx - 1'b1;
                            sleep_n_stages[idx - 1'b1] <= 1'b0;
                        end
                    end else if (!elapsed) begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_ERR: begin
                    sleep_n_stages <= '0;
                    pwr_ack        <= 1'b0;
                    busy           <= 1'b0;
                    if (err_clr && !pwr_req) begin
                        state <= S_OFF;
                        err   <= 1'b0;
                    end
                end

                default: begin
                    state          <= S_OFF;
                    idx            <= '0;
                    dly_cnt        <= '0;
                    tmo_cnt        <= '0;
                    sleep_n_stages <= '0;
                    pwr_ack        <= 1'b0;
                    busy           <= 1'b0;
                    err            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Bench for power_switch_sequencer: directed ramp/abort/timeout/reset scenarios followed by random
// request/ack traffic, every cycle compared against a stage-count reference model.
module tb_power_switch_sequencer;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int TW   = 4;
    localparam int TMAX = (1 << TW) - 1;

    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_ON   = 2;
    localparam int M_DOWN = 3;
    localparam int M_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwr_req;
    logic [DW-1:0] stage_dly;
    logic [N-1:0]  stage_ack;
    logic          err_clr;
    logic [N-1:0]  sleep_n_stages;
    logic          pwr_ack;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: number of stages powered plus a mode, waiting and timeout counters.
    int m_mode, m_level, m_d, m_wait, m_tmo;

    int           ack_mode;
    logic [N-1:0] stuck_low;
    logic [N-1:0] prev_sleep;

    always #5 clk = ~clk;

    power_switch_sequencer #(.NUM_STAGES(N), .DLY_W(DW), .TMO_W(TW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwr_req        (pwr_req),
        .stage_dly      (stage_dly),
        .stage_ack      (stage_ack),
        .err_clr        (err_clr),
        .sleep_n_stages (sleep_n_stages),
        .pwr_ack        (pwr_ack),
        .busy           (busy),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_sleep();
        return N'((1 << m_level) - 1);
    endfunction

    task automatic model_reset();
        m_mode = M_OFF; m_level = 0; m_d = 1; m_wait = 0; m_tmo = 0;
    endtask

    task automatic model_latch();
        m_d    = (stage_dly == 0) ? 1 : int'(stage_dly);
        m_wait = 0;
        m_tmo  = 0;
    endtask

    task automatic model_edge();
        bit elapsed;
        elapsed = (m_wait >= m_d - 1);
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_OFF: if (pwr_req) begin m_mode = M_UP; m_level = 1; model_latch(); end
            M_UP: begin
                if (m_tmo == TMAX) begin m_mode = M_ERR; m_level = 0; end
                else if (!pwr_req) begin m_mode = M_DOWN; m_level--; model_latch(); end
                else if (elapsed && stage_ack[m_level-1]) begin
                    m_wait = 0; m_tmo = 0;
                    if (m_level == N) m_mode = M_ON;
                    else m_level++;
                end
                else if (!elapsed) m_wait++;
                else m_tmo++;
            end
            M_ON: if (!pwr_req) begin m_mode = M_DOWN; m_level = N - 1; model_latch(); end
            M_DOWN: begin
                if (m_tmo == TMAX) begin m_mode = M_ERR; m_level = 0; end
                else if (pwr_req) begin m_mode = M_UP; m_level++; model_latch(); end
                else if (elapsed && !stage_ack[m_level]) begin
                    m_wait = 0; m_tmo = 0;
                    if (m_level == 0) m_mode = M_OFF;
                    else m_level--;
                end
                else if (!elapsed) m_wait++;
                else m_tmo++;
            end
            default: if (err_clr && !pwr_req) m_mode = M_OFF;
        endcase
    endtask

    task automatic check_outputs();
        check("sleep_n", 32'(sleep_n_stages), 32'(exp_sleep()));
        check("pwr_ack", 32'(pwr_ack), 32'(m_mode == M_ON));
        check("busy",    32'(busy),    32'(m_mode == M_UP || m_mode == M_DOWN));
        check("err",     32'(err),     32'(m_mode == M_ERR));
    endtask

    task automatic update_ack();
        case (ack_mode)
            0: stage_ack = sleep_n_stages & ~stuck_low;
            1: begin stage_ack = prev_sleep; prev_sleep = sleep_n_stages; end
            default: for (int i = 0; i < N; i++)
                         if ($urandom_range(3) != 0) stage_ack[i] = sleep_n_stages[i];
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        update_ack();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit saw7;
        rst_n = 1'b1; pwr_req = 1'b0; err_clr = 1'b0; stage_dly = 8'd3;
        stage_ack = '0; stuck_low = '0; prev_sleep = '0; ack_mode = 1;
        model_reset();

        // asynchronous reset with no clock edge
        #2 rst_n = 1'b0;
        #1 check_outputs();
        step(); step();
        rst_n = 1'b1;
        step(); step();

        // ramp up, D=3, acks lag one cycle
        pwr_req = 1'b1;
        cnt = 0;
        while (!pwr_ack && cnt < 40) begin step(); cnt++; end
        check("up_latency", 32'(cnt), 32'(1 + N * 3));

        // ramp down, D=2
        stage_dly = 8'd2;
        pwr_req = 1'b0;
        step();
        cnt = 0;
        while (busy && cnt < 60) begin step(); cnt++; end
        check("down_finished", 32'(cnt < 60), 32'd1);
        check("down_sleep", 32'(sleep_n_stages), 32'd0);

        // abort mid-ramp at 0011
        stage_dly = 8'd3;
        pwr_req = 1'b1;
        cnt = 0;
        while (sleep_n_stages != 4'b0011 && cnt < 40) begin step(); cnt++; end
        check("reach_0011", 32'(sleep_n_stages), 32'h3);
        pwr_req = 1'b0;
        step();
        check("abort_next", 32'(sleep_n_stages), 32'h1);
        saw7 = 1'b0;
        cnt = 0;
        while (busy && cnt < 60) begin
            step(); cnt++;
            if (sleep_n_stages == 4'b0111) saw7 = 1'b1;
        end
        check("abort_no_0111", 32'(saw7), 32'd0);
        check("abort_off", 32'(sleep_n_stages), 32'd0);

        // ack timeout on stage 1
        ack_mode = 0; stuck_low = 4'b0010; stage_ack = '0;
        stage_dly = 8'd2;
        pwr_req = 1'b1;
        cnt = 0;
        while (!err && cnt < 80) begin step(); cnt++; end
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_sleep", 32'(sleep_n_stages), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_ignored", 32'(err), 32'd1);
        step();
        pwr_req = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_done", 32'(err), 32'd0);
        stuck_low = '0;
        step();

        // zero delay ramp, then async reset at 0111
        stage_dly = 8'd0;
        pwr_req = 1'b1;
        cnt = 0;
        while (sleep_n_stages != 4'b0111 && cnt < 20) begin step(); cnt++; end
        check("fast_ramp_steps", 32'(cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step();
        rst_n = 1'b1;
        step();
        check("restart_stage0", 32'(sleep_n_stages), 32'h1);
        step(); step();

        // random traffic
        ack_mode = 2;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(15) == 0) pwr_req = ~pwr_req;
            stage_dly = 8'($urandom_range(4));
            err_clr = ($urandom_range(7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
